doublecrack: RTL and testbench

- Brute-force ARC4 key cracker with two parallel search engines.
- Copies a length-prefixed ciphertext from an external synchronous ROM into a local buffer.
- Engine 0 tests even 24-bit keys and engine 1 tests odd keys.
- Reports the first key whose decryption is entirely printable ASCII. Sits beside the ciphertext ROM at the top of the task.

---
 rtl/doublecrack_pkg.sv | 19 +
 rtl/crack_core.sv | 126 ++++++++++++
 rtl/doublecrack.sv | 97 +++++++++
 tb/tb_doublecrack.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/doublecrack_pkg.sv
// Shared types and constants for the doublecrack ARC4 key search.
package doublecrack_pkg;

  typedef enum logic [1:0] {IDLE, COPY, SEARCH, DONE} top_state_t;

  typedef enum logic [3:0] {
    ENG_IDLE, INIT, KSA_READ_I, KSA_READ_J, KSA_SWAP,
    PRGA_STEP, PRGA_READ, PRGA_CHECK, NEXT_KEY, FOUND, EXHAUSTED
  } eng_state_t;

  localparam logic [7:0]  PRINT_MIN = 8'h20;
  localparam logic [7:0]  PRINT_MAX = 8'h7E;
  localparam logic [23:0] KEY_MAX   = 24'hFFFFFF;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_MIN) && (b <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/crack_core.sv
// One ARC4 search engine: walks keys START_KEY, START_KEY+2, ... and stops on the
// first key whose decryption of the buffered message is entirely printable.
module crack_core
  import doublecrack_pkg::*;
#(
  parameter logic [23:0] START_KEY = 24'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  len,
  output logic [7:0]  buf_addr,
  input  logic [7:0]  buf_data,
  output logic        found,
  output logic        exhausted,
  output logic [23:0] key
);

  eng_state_t  state, state_next;
  logic [7:0]  s [256];
  logic [7:0]  i, j, si, sj, n;
  logic [1:0]  kidx;
  logic        failed;
  logic [23:0] kcur;
  logic [7:0]  key_byte, ksa_j, prga_j, t, pad, plain;

  // The pad is read in the same cycle as the swap is written, so forward the
  // swapped values when the pad index lands on i or j.
  always_comb begin
    case (kidx)
      2'd0:    key_byte = kcur[23:16];
      2'd1:    key_byte = kcur[15:8];
      default: key_byte = kcur[7:0];
    endcase
    ksa_j  = j + si + key_byte;
    prga_j = j + s[i];
    t      = si + sj;
    if (t == i)      pad = sj;
    else if (t == j) pad = si;
    else             pad = s[t];
    plain = buf_data ^ pad;
  end

  assign buf_addr  = n;
  assign found     = (state == FOUND);
  assign exhausted = (state == EXHAUSTED);
  assign key       = kcur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ENG_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) state_next = INIT;
    else if (stop) state_next = ENG_IDLE;
    else begin
      case (state)
        INIT:       state_next = KSA_READ_I;
        KSA_READ_I: state_next = KSA_READ_J;
        KSA_READ_J: state_next = KSA_SWAP;
        KSA_SWAP:   state_next = (i == 8'hFF) ? PRGA_STEP : KSA_READ_I;
        PRGA_STEP:  if (n == len) state_next = failed ? NEXT_KEY : FOUND;
                    else          state_next = PRGA_READ;
        PRGA_READ:  state_next = PRGA_CHECK;
        PRGA_CHECK: state_next = PRGA_STEP;
        NEXT_KEY:   state_next = (kcur >= KEY_MAX - 24'd1) ? EXHAUSTED : INIT;
        default:    state_next = state;
      endcase
    end
  end

  // A failing byte only marks the candidate; the PRGA still runs all len bytes so
  // both engines stay in lockstep and ties resolve in key order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i <= '0; j <= '0; si <= '0; sj <= '0; n <= '0;
      kidx <= '0; failed <= 1'b0; kcur <= START_KEY;
    end else if (start) begin
      kcur <= START_KEY;
      failed <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          i <= '0; j <= '0; kidx <= '0;
        end
        KSA_READ_I: si <= s[i];
        KSA_READ_J: begin
          j  <= ksa_j;
          sj <= s[ksa_j];
        end
        KSA_SWAP: begin
          i    <= i + 8'd1;
          kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
          if (i == 8'hFF) begin
            j <= '0; n <= '0; failed <= 1'b0;
          end
        end
        PRGA_STEP: if (n != len) begin
          i <= i + 8'd1;
          n <= n + 8'd1;
        end
        PRGA_READ: begin
          si <= s[i];
          j  <= prga_j;
          sj <= s[prga_j];
        end
        PRGA_CHECK: if (!is_printable(plain)) failed <= 1'b1;
        NEXT_KEY: if (kcur < KEY_MAX - 24'd1) kcur <= kcur + 24'd2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int x = 0; x < 256; x++) s[x] <= 8'(x);
    end else if (state == KSA_SWAP || state == PRGA_CHECK) begin
      s[i] <= sj;
      s[j] <= si;
    end
  end

endmodule

// File: rtl/doublecrack.sv
// Top of the cracker: copies the length-prefixed ciphertext from ROM, runs the even
// and odd key engines together, and latches the first winning key.
module doublecrack
  import doublecrack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic [7:0]  ct_addr,
  input  logic [7:0]  ct_rddata
);

  top_state_t  state, state_next;
  logic [7:0]  ct_buf [256];
  logic [7:0]  len, len_eff, cap_addr;
  logic        issue, issue_ok, cap_valid, copy_done, start_eng, eng_stop;
  logic [7:0]  buf_addr0, buf_addr1;
  logic        found0, found1, exh0, exh1;
  logic [23:0] key0, key1;

  // Address 1 goes out before the length byte is back; a zero length withdraws it.
  assign len_eff   = (cap_valid && cap_addr == 8'd0) ? ct_rddata : len;
  assign issue_ok  = issue && (ct_addr == 8'd0 || ct_addr <= len_eff);
  assign copy_done = cap_valid && (cap_addr == len_eff);
  assign rdy       = (state == IDLE) || (state == DONE);
  assign eng_stop  = (state != SEARCH);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (en) state_next = COPY;
      COPY:       if (copy_done) state_next = SEARCH;
      SEARCH:     if (found0 || found1 || (exh0 && exh1)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ct_addr <= '0; issue <= 1'b0; cap_valid <= 1'b0; cap_addr <= '0;
      len <= '0; start_eng <= 1'b0; key <= '0; key_valid <= 1'b0;
    end else begin
      start_eng <= 1'b0;
      case (state)
        IDLE, DONE: if (en) begin
          ct_addr <= '0; issue <= 1'b1; cap_valid <= 1'b0;
          key <= '0; key_valid <= 1'b0;
        end
        COPY: begin
          cap_valid <= issue_ok;
          cap_addr  <= ct_addr;
          if (issue) begin
            if (!issue_ok) begin
              ct_addr <= '0; issue <= 1'b0;
            end else if (ct_addr == 8'd0 || ct_addr < len_eff) ct_addr <= ct_addr + 8'd1;
            else issue <= 1'b0;
          end
          if (cap_valid && cap_addr == 8'd0) len <= ct_rddata;
          if (copy_done) start_eng <= 1'b1;
        end
        SEARCH: begin
          if (found0) begin
            key <= key0; key_valid <= 1'b1;
          end else if (found1) begin
            key <= key1; key_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == COPY && cap_valid) ct_buf[cap_addr] <= ct_rddata;
  end

  crack_core #(.START_KEY(24'd0)) u_even (
    .clk(clk), .rst(rst_n), .start(start_eng), .stop(eng_stop), .len(len),
    .buf_addr(buf_addr0), .buf_data(ct_buf[buf_addr0]),
    .found(found0), .exhausted(exh0), .key(key0)
  );

  crack_core #(.START_KEY(24'd1)) u_odd (
    .clk(clk), .rst(rst_n), .start(start_eng), .stop(eng_stop), .len(len),
    .buf_addr(buf_addr1), .buf_data(ct_buf[buf_addr1]),
    .found(found1), .exhausted(exh1), .key(key1)
  );

endmodule

// File: tb/tb_doublecrack.sv
// Directed bench for doublecrack: a software ARC4 model builds messages and predicts
// the lowest passing key, which both engines must agree on.
module tb_doublecrack;

  logic        clk, rst_n, en, rdy, key_valid;
  logic [23:0] key;
  logic [7:0]  ct_addr, ct_rddata;
  logic [7:0]  rom [256];
  logic [7:0]  ks  [256];
  int checks, passed;

  doublecrack dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
    .key_valid(key_valid), .ct_addr(ct_addr), .ct_rddata(ct_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ct_rddata <= rom[ct_addr];

  function automatic bit printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  function automatic void gen_stream(input logic [23:0] k, input int len);
    logic [7:0] st [256];
    logic [7:0] kb [3];
    logic [7:0] a, b, tmp, idx;
    kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
    for (int x = 0; x < 256; x++) st[x] = 8'(x);
    b = 8'd0;
    for (int x = 0; x < 256; x++) begin
      b = b + st[x] + kb[x % 3];
      tmp = st[x]; st[x] = st[b]; st[b] = tmp;
    end
    a = 8'd0; b = 8'd0;
    for (int n = 0; n < len; n++) begin
      a = a + 8'd1;
      b = b + st[a];
      tmp = st[a]; st[a] = st[b]; st[b] = tmp;
      idx = st[a] + st[b];
      ks[n] = st[idx];
    end
  endfunction

  function automatic int first_pass();
    int len;
    bit ok;
    len = int'(rom[0]);
    for (int k = 0; k < 4096; k++) begin
      gen_stream(24'(k), len);
      ok = 1'b1;
      for (int n = 1; n <= len; n++) if (!printable(rom[n] ^ ks[n-1])) ok = 1'b0;
      if (ok) return k;
    end
    return -1;
  endfunction

  // Builds a 1-byte message for key target that every lower key decrypts to junk.
  function automatic void pick_msg(input int target);
    logic [7:0] c;
    bit ok;
    rom[0] = 8'd1;
    for (int p = 32; p <= 126; p++) begin
      gen_stream(24'(target), 1);
      c = 8'(p) ^ ks[0];
      ok = 1'b1;
      for (int k = 0; k < target; k++) begin
        gen_stream(24'(k), 1);
        if (printable(c ^ ks[0])) ok = 1'b0;
      end
      rom[1] = c;
      if (ok) return;
    end
  endfunction

  function automatic int budget_for(input int exp_key);
    if (exp_key < 0) return 3000;
    return (exp_key / 2 + 2) * (800 + 3 * int'(rom[0])) + 50;
  endfunction

  task automatic pulse_en();
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out, output int bad);
    timed_out = 1'b1; bad = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin timed_out = 1'b0; break; end
      if (key_valid !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset();
    for (int x = 0; x < 256; x++) rom[x] = 8'h00;
    rst_n = 1'b0; en = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (rdy !== 1'b1) $display("[TB] FAIL reset_rdy got %b want 1", rdy); else passed++;
    checks++; if (key_valid !== 1'b0) $display("[TB] FAIL reset_kv got %b want 0", key_valid); else passed++;
    checks++; if (key !== 24'h0) $display("[TB] FAIL reset_key got %h want 000000", key); else passed++;
    checks++; if (ct_addr !== 8'h0) $display("[TB] FAIL reset_addr got %h want 00", ct_addr); else passed++;
    @(negedge clk); rst_n = 1'b0;
  endtask

  task automatic test_empty_message();
    int exp_key, bad; bit to;
    rom[0] = 8'h00;
    exp_key = first_pass();
    pulse_en();
    checks++; if (rdy !== 1'b0) $display("[TB] FAIL empty_busy got %b want 0", rdy); else passed++;
    checks++; if (key_valid !== 1'b0) $display("[TB] FAIL empty_kv_drop got %b want 0", key_valid); else passed++;
    checks++; if (ct_addr !== 8'h00) $display("[TB] FAIL empty_addr0 got %h want 00", ct_addr); else passed++;
    wait_done(1500, to, bad);
    checks++; if (to !== 1'b0) $display("[TB] FAIL empty_timeout got timeout=%b want 0", to); else passed++;
    checks++; if (key_valid !== 1'b1) $display("[TB] FAIL empty_kv got %b want 1", key_valid); else passed++;
    checks++; if (key !== 24'(exp_key)) $display("[TB] FAIL empty_key got %h want %h", key, 24'(exp_key)); else passed++;
    checks++; if (ct_addr !== 8'h00) $display("[TB] FAIL empty_addr_hold got %h want 00", ct_addr); else passed++;
  endtask

  task automatic test_even_key();
    int exp_key, bad; bit to;
    pick_msg(2);
    exp_key = first_pass();
    pulse_en();
    wait_done(budget_for(exp_key), to, bad);
    checks++; if (to !== 1'b0) $display("[TB] FAIL even_timeout got timeout=%b want 0", to); else passed++;
    checks++; if (key_valid !== 1'b1) $display("[TB] FAIL even_kv got %b want 1", key_valid); else passed++;
    checks++; if (key !== 24'(exp_key)) $display("[TB] FAIL even_key got %h want %h", key, 24'(exp_key)); else passed++;
  endtask

  task automatic test_odd_key();
    int exp_key, bad; bit to;
    pick_msg(1);
    exp_key = first_pass();
    pulse_en();
    wait_done(budget_for(exp_key), to, bad);
    checks++; if (to !== 1'b0) $display("[TB] FAIL odd_timeout got timeout=%b want 0", to); else passed++;
    checks++; if (key_valid !== 1'b1) $display("[TB] FAIL odd_kv got %b want 1", key_valid); else passed++;
    checks++; if (key !== 24'(exp_key)) $display("[TB] FAIL odd_key got %h want %h", key, 24'(exp_key)); else passed++;
  endtask

  task automatic test_reference(output int exp_key);
    int bad; bit to;
    rom[0] = 8'd2;
    gen_stream(24'h000018, 2);
    rom[1] = 8'h68 ^ ks[0];
    rom[2] = 8'h69 ^ ks[1];
    exp_key = first_pass();
    pulse_en();
    for (int a = 0; a <= 2; a++) begin
      checks++;
      if (ct_addr !== 8'(a)) $display("[TB] FAIL copy_addr%0d got %h want %h", a, ct_addr, 8'(a));
      else passed++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++; if (ct_addr !== 8'd2) $display("[TB] FAIL copy_addr_hold got %h want 02", ct_addr); else passed++;
    wait_done(budget_for(exp_key), to, bad);
    checks++; if (to !== 1'b0) $display("[TB] FAIL ref_timeout got timeout=%b want 0", to); else passed++;
    checks++; if (key_valid !== 1'b1) $display("[TB] FAIL ref_kv got %b want 1", key_valid); else passed++;
    checks++; if (key !== 24'(exp_key)) $display("[TB] FAIL ref_key got %h want %h", key, 24'(exp_key)); else passed++;
  endtask

  task automatic test_back_to_back(input int exp_key);
    int bad; bit to;
    pulse_en();
    checks++; if (key_valid !== 1'b0) $display("[TB] FAIL b2b_kv_drop got %b want 0", key_valid); else passed++;
    checks++; if (ct_addr !== 8'h00) $display("[TB] FAIL b2b_addr0 got %h want 00", ct_addr); else passed++;
    checks++; if (rdy !== 1'b0) $display("[TB] FAIL b2b_busy got %b want 0", rdy); else passed++;
    wait_done(budget_for(exp_key), to, bad);
    checks++; if (to !== 1'b0) $display("[TB] FAIL b2b_timeout got timeout=%b want 0", to); else passed++;
    checks++; if (key_valid !== 1'b1) $display("[TB] FAIL b2b_kv got %b want 1", key_valid); else passed++;
    checks++; if (key !== 24'(exp_key)) $display("[TB] FAIL b2b_key got %h want %h", key, 24'(exp_key)); else passed++;
  endtask

  task automatic test_constant_rom();
    int exp_key, bad; bit to;
    for (int x = 0; x < 256; x++) rom[x] = 8'h02;
    exp_key = first_pass();
    pulse_en();
    wait_done(budget_for(exp_key), to, bad);
    checks++; if (bad !== 0) $display("[TB] FAIL const_kv_early got %0d cycles want 0", bad); else passed++;
    checks++; if (to !== 1'b0) $display("[TB] FAIL const_timeout got timeout=%b want 0", to); else passed++;
    checks++; if (key_valid !== 1'b1) $display("[TB] FAIL const_kv got %b want 1", key_valid); else passed++;
    checks++; if (key !== 24'(exp_key)) $display("[TB] FAIL const_key got %h want %h", key, 24'(exp_key)); else passed++;
  endtask

  task automatic test_ignore_en_and_abort();
    pulse_en();
    repeat (40) @(negedge clk);
    pulse_en();
    repeat (2) @(negedge clk);
    checks++; if (rdy !== 1'b0) $display("[TB] FAIL busy_en_rdy got %b want 0", rdy); else passed++;
    checks++; if (ct_addr !== 8'd2) $display("[TB] FAIL busy_en_addr got %h want 02", ct_addr); else passed++;
    checks++; if (key_valid !== 1'b0) $display("[TB] FAIL busy_en_kv got %b want 0", key_valid); else passed++;
    #2 rst_n = 1'b1;
    #1;
    checks++; if (rdy !== 1'b1) $display("[TB] FAIL abort_rdy got %b want 1", rdy); else passed++;
    checks++; if (key_valid !== 1'b0) $display("[TB] FAIL abort_kv got %b want 0", key_valid); else passed++;
    checks++; if (key !== 24'h0) $display("[TB] FAIL abort_key got %h want 000000", key); else passed++;
    checks++; if (ct_addr !== 8'h00) $display("[TB] FAIL abort_addr got %h want 00", ct_addr); else passed++;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int ref_key;
    checks = 0; passed = 0;
    test_reset();
    test_empty_message();
    test_even_key();
    test_odd_key();
    test_reference(ref_key);
    test_back_to_back(ref_key);
    test_constant_rom();
    test_ignore_en_and_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
